bp_clint_responder: RTL and testbench

- Memory-mapped responder for the CLINT device window (device field 3, base 0x0030_0000).
- Decodes uncached load/store commands addressed to the mipi, mtimecmp, mtime and plic registers, and returns one response per command.
- Maintains the free-running mtime counter and drives the software, timer and external interrupt lines into the core.
- Sits between the local I/O router and the core's interrupt inputs; single hart.

---
 rtl/bp_clint_responder.sv | 158 +++++++++++++++
 tb/tb_bp_clint_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_clint_responder.sv
`default_nettype none
// ------------------------------------------------------------------------------
// bp_clint_responder: CLINT mipi/mtimecmp/mtime/plic responder with mtime, rev 1.0
// ------------------------------------------------------------------------------
module bp_clint_responder #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64,
  parameter int rtc_div_p     = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic [paddr_width_p-1:0] cmd_addr_i,
  input  logic                     cmd_we_i,
  input  logic                     cmd_size_i,
  input  logic [data_width_p-1:0]  cmd_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,
  output logic                     software_irq_o,
  output logic                     timer_irq_o,
  output logic                     external_irq_o
);

  localparam int                 c_div_w   = (rtc_div_p > 1) ? $clog2(rtc_div_p) : 1;
  localparam logic [c_div_w-1:0] c_div_max = c_div_w'(rtc_div_p - 1);

  localparam logic [19:0] c_off_mipi     = 20'h0_0000;
  localparam logic [19:0] c_off_mtimecmp = 20'h0_4000;
  localparam logic [19:0] c_off_plic     = 20'h0_B000;
  localparam logic [19:0] c_off_mtime    = 20'h0_BFF8;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_resp = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [data_width_p-1:0] resp_data_q, resp_data_d;
  logic                    resp_err_q, resp_err_d;
  logic [c_div_w-1:0]      div_q, div_d;
  logic [63:0]             mtime_q, mtime_d;
  logic [63:0]             mtimecmp_q, mtimecmp_d;
  logic                    mipi_q, mipi_d;
  logic                    plic_q, plic_d;
  logic                    timer_irq_q;

  logic [19:0] w_word;
  logic        w_sel_mipi, w_sel_mtimecmp, w_sel_plic, w_sel_mtime, w_mapped;
  logic        w_hi, w_accept, w_wr, w_tick, w_low_ok;
  logic [63:0] w_rd_full, w_rd_data;
  logic        w_unused;

  assign w_unused = ^{cmd_addr_i[paddr_width_p-1:20], cmd_addr_i[1:0]};

  // Size-4 store: replace only the addressed half, keep the other.
  function automatic logic [63:0] f_merge(input logic [63:0] old_v, input logic [63:0] wdata,
                                          input logic size8, input logic hi);
    if (size8)   return wdata;
    else if (hi) return {wdata[31:0], old_v[31:0]};
    else         return {old_v[63:32], wdata[31:0]};
  endfunction

  assign w_word         = {cmd_addr_i[19:3], 3'b000};
  assign w_hi           = cmd_addr_i[2];
  assign w_sel_mipi     = (w_word == c_off_mipi);
  assign w_sel_mtimecmp = (w_word == c_off_mtimecmp);
  assign w_sel_plic     = (w_word == c_off_plic);
  assign w_sel_mtime    = (w_word == c_off_mtime);
  assign w_mapped       = w_sel_mipi | w_sel_mtimecmp | w_sel_plic | w_sel_mtime;

  assign w_accept = cmd_v_i & (state_q == e_idle);
  assign w_wr     = w_accept & cmd_we_i;
  assign w_low_ok = cmd_size_i | ~w_hi;

  always_comb begin
    w_rd_full = '0;
    if (w_sel_mipi)          w_rd_full = {63'b0, mipi_q};
    else if (w_sel_plic)     w_rd_full = {63'b0, plic_q};
    else if (w_sel_mtimecmp) w_rd_full = mtimecmp_q;
    else if (w_sel_mtime)    w_rd_full = mtime_q;
  end

  assign w_rd_data = cmd_size_i ? w_rd_full
                                : {32'b0, (w_hi ? w_rd_full[63:32] : w_rd_full[31:0])};

  assign w_tick = (div_q == c_div_max);
  assign div_d  = w_tick ? '0 : div_q + 1'b1;

  // An mtime store overrides a coincident tick; the divider keeps running.
  always_comb begin
    mtime_d    = w_tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    mipi_d     = mipi_q;
    plic_d     = plic_q;
    if (w_wr && w_sel_mtime)    mtime_d    = f_merge(mtime_q, cmd_data_i, cmd_size_i, w_hi);
    if (w_wr && w_sel_mtimecmp) mtimecmp_d = f_merge(mtimecmp_q, cmd_data_i, cmd_size_i, w_hi);
    if (w_wr && w_sel_mipi && w_low_ok) mipi_d = cmd_data_i[0];
    if (w_wr && w_sel_plic && w_low_ok) plic_d = cmd_data_i[0];
  end

  always_comb begin
    state_d     = state_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    cmd_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (state_q)
      e_idle: begin
        cmd_ready_o = 1'b1;
        if (w_accept) begin
          state_d     = e_resp;
          resp_data_d = (cmd_we_i || !w_mapped) ? '0 : w_rd_data;
          resp_err_d  = ~w_mapped;
        end
      end
      e_resp: begin
        resp_v_o = 1'b1;
        if (resp_ready_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      div_q       <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      mipi_q      <= 1'b0;
      plic_q      <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      div_q       <= div_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      mipi_q      <= mipi_d;
      plic_q      <= plic_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;
  assign software_irq_o = mipi_q;
  assign external_irq_o = plic_q;
  assign timer_irq_o    = timer_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_clint_responder.sv
`default_nettype none
// ------------------------------------------------------------------------------
// tb_bp_clint_responder: directed self-checking bench for bp_clint_responder, rev 1.0
// ------------------------------------------------------------------------------
module tb_bp_clint_responder;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        cmd_v_i = 1'b0;
  logic        cmd_ready_o;
  logic [39:0] cmd_addr_i = '0;
  logic        cmd_we_i = 1'b0;
  logic        cmd_size_i = 1'b0;
  logic [63:0] cmd_data_i = '0;
  logic        resp_v_o;
  logic        resp_ready_i = 1'b1;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        software_irq_o, timer_irq_o, external_irq_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  localparam logic [39:0] A_MIPI = 40'h30_0000;
  localparam logic [39:0] A_CMP  = 40'h30_4000;
  localparam logic [39:0] A_PLIC = 40'h30_B000;
  localparam logic [39:0] A_TIME = 40'h30_BFF8;
  localparam logic [39:0] A_BAD  = 40'h30_1000;

  bp_clint_responder #(.paddr_width_p(40), .data_width_p(64), .rtc_div_p(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_we_i(cmd_we_i), .cmd_size_i(cmd_size_i), .cmd_data_i(cmd_data_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o), .software_irq_o(software_irq_o),
    .timer_irq_o(timer_irq_o), .external_irq_o(external_irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Edges since reset release; mtime should equal cyc/8 absent stores.
  always @(posedge clk_i) cyc <= reset_i ? 0 : cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic sz, input logic [39:0] a,
                       input logic [63:0] d, input logic rr);
    int waited = 0;
    cmd_v_i = 1'b1; cmd_we_i = we; cmd_size_i = sz; cmd_addr_i = a; cmd_data_i = d;
    resp_ready_i = rr;
    while (!cmd_ready_o && waited < 20) begin step(); waited++; end
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL issue_ready: got %0b want 1", cmd_ready_o);
    end
    step();
    cmd_v_i = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic sz, input logic [39:0] a,
                      input logic [63:0] d, output logic [63:0] rd, output logic er);
    issue(we, sz, a, d, 1'b1);
    n_cmp++;
    if (resp_v_o !== 1'b1) begin
      n_bad++; $display("FAIL xfer_resp_v: got %0b want 1", resp_v_o);
    end
    rd = resp_data_o;
    er = resp_err_o;
    step();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({resp_v_o, resp_err_o, software_irq_o, timer_irq_o, external_irq_o} !== 5'b0) begin
      n_bad++; $display("FAIL reset_outs: got %b want 00000",
                        {resp_v_o, resp_err_o, software_irq_o, timer_irq_o, external_irq_o});
    end
    n_cmp++;
    if (resp_data_o !== 64'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", resp_data_o);
    end
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %0b want 1", cmd_ready_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_idle_mtime();
    logic seen = 1'b0;
    logic [63:0] rd, exp;
    logic er;
    int c;
    for (int i = 0; i < 80; i++) begin
      step();
      if (timer_irq_o !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL idle_timer_irq: got 1 want 0");
    end
    c = cyc;
    exp = 64'(c / 8);
    xfer(1'b0, 1'b1, A_TIME, 64'h0, rd, er);
    n_cmp++;
    if (rd !== exp) begin
      n_bad++; $display("FAIL idle_mtime: got %h want %h", rd, exp);
    end
    n_cmp++;
    if (er !== 1'b0) begin
      n_bad++; $display("FAIL idle_err: got %0b want 0", er);
    end
  endtask

  task automatic test_timer();
    logic [63:0] rd;
    logic er;
    int k = 0;
    xfer(1'b1, 1'b1, A_CMP, 64'h20, rd, er);
    while (cyc < 256 && k < 400) begin step(); k++; end
    n_cmp++;
    if (timer_irq_o !== 1'b0) begin
      n_bad++; $display("FAIL timer_early: got %0b want 0 at cyc %0d", timer_irq_o, cyc);
    end
    step();
    n_cmp++;
    if (timer_irq_o !== 1'b1) begin
      n_bad++; $display("FAIL timer_rise: got %0b want 1 at cyc %0d", timer_irq_o, cyc);
    end
  endtask

  task automatic test_cmp_half();
    logic [63:0] rd;
    logic er;
    issue(1'b1, 1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    n_cmp++;
    if (timer_irq_o !== 1'b1) begin
      n_bad++; $display("FAIL cmp_store_lag: got %0b want 1", timer_irq_o);
    end
    step();
    n_cmp++;
    if (timer_irq_o !== 1'b0) begin
      n_bad++; $display("FAIL cmp_store_fall: got %0b want 0", timer_irq_o);
    end
    xfer(1'b1, 1'b0, A_CMP + 40'h4, 64'h0000_0000_DEAD_BEEF, rd, er);
    xfer(1'b0, 1'b1, A_CMP, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'hDEAD_BEEF_FFFF_FFFF) begin
      n_bad++; $display("FAIL cmp_load8: got %h want deadbeefffffffff", rd);
    end
    xfer(1'b0, 1'b0, A_CMP + 40'h4, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'h0000_0000_DEAD_BEEF) begin
      n_bad++; $display("FAIL cmp_load4_hi: got %h want 00000000deadbeef", rd);
    end
    xfer(1'b0, 1'b0, A_CMP, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'h0000_0000_FFFF_FFFF) begin
      n_bad++; $display("FAIL cmp_load4_lo: got %h want 00000000ffffffff", rd);
    end
  endtask

  task automatic test_irq_regs();
    logic [63:0] rd;
    logic er;
    issue(1'b1, 1'b1, A_MIPI, 64'h1, 1'b1);
    n_cmp++;
    if ({software_irq_o, external_irq_o} !== 2'b10) begin
      n_bad++; $display("FAIL mipi_set: got %b want 10", {software_irq_o, external_irq_o});
    end
    step();
    issue(1'b1, 1'b0, A_PLIC, 64'h1, 1'b1);
    n_cmp++;
    if ({software_irq_o, external_irq_o} !== 2'b11) begin
      n_bad++; $display("FAIL plic_set: got %b want 11", {software_irq_o, external_irq_o});
    end
    step();
    xfer(1'b1, 1'b0, A_MIPI + 40'h4, 64'h0, rd, er);
    n_cmp++;
    if (software_irq_o !== 1'b1) begin
      n_bad++; $display("FAIL mipi_upper_store: got %0b want 1", software_irq_o);
    end
    xfer(1'b0, 1'b1, A_MIPI, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'h1) begin
      n_bad++; $display("FAIL mipi_load: got %h want 1", rd);
    end
    issue(1'b1, 1'b1, A_MIPI, 64'h0, 1'b1);
    n_cmp++;
    if (software_irq_o !== 1'b0) begin
      n_bad++; $display("FAIL mipi_clear: got %0b want 0", software_irq_o);
    end
    step();
    issue(1'b1, 1'b1, A_PLIC, 64'h0, 1'b1);
    n_cmp++;
    if (external_irq_o !== 1'b0) begin
      n_bad++; $display("FAIL plic_clear: got %0b want 0", external_irq_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, A_CMP, 64'h0, 1'b0);
    cmd_v_i = 1'b1; cmd_we_i = 1'b0; cmd_size_i = 1'b0; cmd_addr_i = A_CMP;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({resp_v_o, cmd_ready_o} !== 2'b10 || resp_data_o !== 64'hDEAD_BEEF_FFFF_FFFF) begin
        n_bad++; $display("FAIL stall_%0d: got v/rdy %b data %h want 10 deadbeefffffffff",
                          i, {resp_v_o, cmd_ready_o}, resp_data_o);
      end
      step();
    end
    resp_ready_i = 1'b1;
    step();
    n_cmp++;
    if ({resp_v_o, cmd_ready_o} !== 2'b01) begin
      n_bad++; $display("FAIL b2b_idle: got v/rdy %b want 01", {resp_v_o, cmd_ready_o});
    end
    step();
    cmd_v_i = 1'b0;
    n_cmp++;
    if (resp_v_o !== 1'b1 || resp_data_o !== 64'h0000_0000_FFFF_FFFF) begin
      n_bad++; $display("FAIL b2b_second: got v %0b data %h want 1 00000000ffffffff",
                        resp_v_o, resp_data_o);
    end
    step();
  endtask

  task automatic test_unmapped();
    logic [63:0] rd;
    logic er;
    xfer(1'b0, 1'b1, A_BAD, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'h0 || er !== 1'b1) begin
      n_bad++; $display("FAIL bad_load: got data %h err %0b want 0 1", rd, er);
    end
    xfer(1'b1, 1'b1, A_BAD, 64'hFFFF_FFFF_FFFF_FFFF, rd, er);
    n_cmp++;
    if (rd !== 64'h0 || er !== 1'b1) begin
      n_bad++; $display("FAIL bad_store: got data %h err %0b want 0 1", rd, er);
    end
    n_cmp++;
    if ({software_irq_o, external_irq_o} !== 2'b00) begin
      n_bad++; $display("FAIL bad_store_irq: got %b want 00", {software_irq_o, external_irq_o});
    end
    xfer(1'b0, 1'b1, A_CMP, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'hDEAD_BEEF_FFFF_FFFF || er !== 1'b0) begin
      n_bad++; $display("FAIL bad_store_cmp: got %h err %0b want deadbeefffffffff 0", rd, er);
    end
  endtask

  task automatic align(input int m);
    int k = 0;
    while ((cyc % 8) != m && k < 16) begin step(); k++; end
  endtask

  task automatic test_mtime_wrap();
    logic [63:0] rd;
    logic er;
    align(5);
    xfer(1'b1, 1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFF, rd, er);
    xfer(1'b0, 1'b1, A_TIME, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++; $display("FAIL wrap_before: got %h want ffffffffffffffff", rd);
    end
    xfer(1'b0, 1'b1, A_TIME, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'h0) begin
      n_bad++; $display("FAIL wrap_after: got %h want 0", rd);
    end
    align(7);
    xfer(1'b1, 1'b1, A_TIME, 64'h100, rd, er);
    xfer(1'b0, 1'b1, A_TIME, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'h100) begin
      n_bad++; $display("FAIL store_wins_tick: got %h want 100", rd);
    end
  endtask

  task automatic test_reset_abort();
    logic seen = 1'b0;
    logic [63:0] rd;
    logic er;
    issue(1'b0, 1'b1, A_TIME, 64'h0, 1'b0);
    reset_i = 1'b1;
    step();
    n_cmp++;
    if (resp_v_o !== 1'b0) begin
      n_bad++; $display("FAIL abort_resp_v: got %0b want 0", resp_v_o);
    end
    reset_i = 1'b0;
    resp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (resp_v_o !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL abort_stray_resp: got 1 want 0");
    end
    xfer(1'b0, 1'b1, A_CMP, 64'h0, rd, er);
    n_cmp++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_bad++; $display("FAIL abort_cmp_reset: got %h want ffffffffffffffff", rd);
    end
    n_cmp++;
    if (timer_irq_o !== 1'b0) begin
      n_bad++; $display("FAIL abort_timer: got %0b want 0", timer_irq_o);
    end
  endtask

  initial begin
    test_reset();
    test_idle_mtime();
    test_timer();
    test_cmp_half();
    test_irq_regs();
    test_back_to_back();
    test_unmapped();
    test_mtime_wrap();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
